sd_spi_card: RTL
================

Name: sd_spi_card

Overview:
- SPI-mode SD card responder: the card end of the link driven by the hazard3 SD driver and sd_controller.
- Oversamples SPI mode 0 on the system clock and decodes a subset of SD SPI commands: CMD0/8/16/17/24/55/58 and ACMD41.
- Serves single-block reads and writes from a byte-wide backing memory with 1-cycle read latency (sdspibram-style).
- Used as a synthesizable card model for SoC simulation and FPGA loopback.

Parameters:
- ADDR_W, 24, backing memory byte-address width.
- INIT_RETRIES, 2, number of ACMD41 responses of 0x01 before 0x00.
- NAC_BYTES, 2, 0xFF bytes sent between R1 and the 0xFE read token.
- BUSY_BYTES, 4, 0x00 busy bytes after a write data response.

Ports:
- clk  in  1  system clock; spi_clk must be ≤ clk/8.
- reset  in  1  asynchronous, active-high reset.
- spi_clk  in  1  SPI clock from the host.
- spi_cs  in  1  chip select, active low.
- spi_mosi  in  1  host-to-card data.
- spi_miso  out  1  card-to-host data.
- mem_addr  out  ADDR_W  byte address = {arg[ADDR_W-10:0], 9'b0} + offset.
- mem_rd  out  1  read strobe; mem_rdata is valid the next clk.
- mem_rdata  in  8  read data.
- mem_wr  out  1  one-cycle write strobe.
- mem_wdata  out  8  write data.
- card_ready  out  1  high once ACMD41 has returned 0x00.
- card_state  out  4  current FSM state (debug).
- last_cmd  out  6  index of the last accepted command.

Behaviour:
- Reset values: spi_miso=1, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, card_ready=0, card_state=CMD, last_cmd=0, retry count=0.
- Input sync: spi_clk, spi_cs and spi_mosi each pass through a 2-FF synchronizer. Edges are detected on the synchronized clock.
- Mode 0: mosi is sampled on the rising edge. miso shifts on the falling edge.
- The next tx byte is latched at the 8th rising edge, and its MSB drives on the following falling edge.
- Latency: from a synced edge to the miso change is ≤3 clk.
- cs high: spi_miso=1, the bit counter clears, and the FSM returns to CMD in the next clk. This covers mid-command, mid-read and mid-write aborts. Memory bytes already written stay written.
- CMD state collects a 6-byte frame:
  - A first byte whose bits [7:6] are not 01 is discarded.
  - Then 4 argument bytes and 1 CRC byte (CRC is ignored).
  - While collecting, the card transmits 0xFF.
- RESP state: sends 1 byte of 0xFF (NCR), then R1, then any trailing bytes.
- idle_bit = !card_ready.
- Command handling:
  - CMD0: R1 = 0x01; clears card_ready and the retry count.
  - CMD8: R1 = 0x01|0x00 per idle_bit, then 00 00 01 arg[7:0].
  - CMD55: R1 = {7'b0, idle_bit}; sets app_flag, which is cleared by the next command.
  - ACMD41 (CMD41 with app_flag set): R1 = 0x01 while retry count < INIT_RETRIES, incrementing the count. Otherwise R1 = 0x00 and card_ready is set.
  - CMD58: R1, then C0 FF 80 00 (CCS=1, block addressing).
  - CMD16: R1 only.
  - CMD17 or CMD24 while !card_ready: R1 = 0x05, no data phase.
  - Any other command: R1 = 0x04 | idle_bit.
- CMD17 read path:
  - R1 = 0x00.
  - NAC_BYTES of 0xFF, then token 0xFE.
  - RD_DATA: 512 bytes from mem_addr offsets 0..511. Byte n+1 is prefetched (mem_rd pulse) while byte n shifts out.
  - RD_CRC: FF FF, then back to CMD.
- CMD24 write path:
  - R1 = 0x00.
  - WR_WAIT: ignores non-0xFE bytes while sending 0xFF.
  - WR_DATA: 512 bytes received. Each byte issues one mem_wr at offset n one clk after its 8th rising edge.
  - WR_CRC: 2 bytes ignored.
  - WR_RESP: sends 0x05.
  - WR_BUSY: BUSY_BYTES of 0x00, then CMD, which sends 0xFF.
- Offset counter is 9 bits. The end-of-data condition is terminal count 511, so the offset never wraps within a block. Block addresses beyond 2^(ADDR_W-9) truncate.
- A new command frame arriving during RESP/RD/WR phases is ignored until the FSM returns to CMD.
- mem_rd and mem_wr are never asserted in the same clk.

Test Plan:
- Init sequence:
  - Stimulus: CMD0, CMD8(0x1AA), then CMD55+ACMD41 three times, then CMD58.
  - Required: R1 01; R1 01 + 00 00 01 AA; R1 01, 01, 00 for the three ACMD41s; card_ready rises after the third; CMD58 returns 00 C0 FF 80 00.
- Read:
  - Stimulus: after init, memory bytes 0x400..0x5FF hold (i&0xFF); CMD17 arg=2.
  - Required: 00, FF×2, FE, bytes 00..FF,00..FF, then FF FF.
- Write:
  - Stimulus: CMD24 arg=3, FE, 512 bytes (0xFF-i), 2 CRC bytes.
  - Required: 512 mem_wr at addresses 0x600..0x7FF with the correct data, then 0x05, 00×4, FF.
- Framing and idle:
  - Stimulus: byte 0x3F then CMD0 → only CMD0 answered (0x01).
  - Stimulus: CMD17 before init → 0x05 with no FE token.
- Abort:
  - Stimulus: cs raised after 100 read bytes, lowered again, then CMD58.
  - Required: miso=1 while cs is high; CMD58 is answered normally; no stray mem_rd.
- Reset:
  - Stimulus: reset asserted mid-write.
  - Required: all outputs at reset values within 1 clk; card_ready=0.

Source files
------------

// File: rtl/sd_spi_card.sv
// SD card responder in SPI mode 0. SPI pins are oversampled on clk, a subset
// of SD commands is decoded, and single 512-byte blocks are read from or
// written to a byte-wide memory with one cycle of read latency.
module sd_spi_card #(
  parameter int ADDR_W       = 24,
  parameter int INIT_RETRIES = 2,
  parameter int NAC_BYTES    = 2,
  parameter int BUSY_BYTES   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_clk,
  input  logic              spi_cs,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  output logic              card_ready,
  output logic [3:0]        card_state,
  output logic [5:0]        last_cmd
);

  // Block number bits kept from the argument; higher bits are dropped.
  localparam int         ARG_W     = ADDR_W - 9;
  localparam logic [7:0] RETRY_MAX = 8'(INIT_RETRIES);
  localparam logic [8:0] NAC_MAX   = 9'(NAC_BYTES);
  localparam logic [8:0] BUSY_MAX  = 9'(BUSY_BYTES);
  // Idle levels of {mosi, cs, sclk} so reset does not fake an edge.
  localparam logic [2:0] SYNC_RST  = 3'b110;

  typedef enum logic [3:0] {
    S_CMD, S_RESP, S_RD_NAC, S_RD_DATA, S_RD_CRC,
    S_WR_WAIT, S_WR_DATA, S_WR_CRC, S_WR_RESP, S_WR_BUSY
  } state_t;

  logic [2:0] pin_raw;
  logic [2:0] pin_sync;
  assign pin_raw = {spi_mosi, spi_cs, spi_clk};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      logic s1_reg;
      logic s2_reg;
      // Two-flop synchronizer for one SPI pin
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s1_reg <= SYNC_RST[gi];
          s2_reg <= SYNC_RST[gi];
        end else begin
          s1_reg <= pin_raw[gi];
          s2_reg <= s1_reg;
        end
      end
      assign pin_sync[gi] = s2_reg;
    end
  endgenerate

  logic sclk_s, cs_s, mosi_s;
  logic sclk_prev_reg;
  logic rise, fall, byte_done;
  logic [2:0] bit_cnt_reg;
  logic [6:0] rx_sr_reg;
  logic [7:0] tx_sr_reg;
  logic [7:0] rx_byte;
  logic [7:0] tx_load;
  logic       miso_reg;

  assign sclk_s    = pin_sync[0];
  assign cs_s      = pin_sync[1];
  assign mosi_s    = pin_sync[2];
  assign rise      = sclk_s & ~sclk_prev_reg & ~cs_s;
  assign fall      = ~sclk_s & sclk_prev_reg & ~cs_s;
  assign byte_done = rise && (bit_cnt_reg == 3'd7);
  assign rx_byte   = {rx_sr_reg, mosi_s};

  // Bit-level shifter: sample on rise, shift out on fall, reload each byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_prev_reg <= 1'b0;
      bit_cnt_reg   <= 3'd0;
      rx_sr_reg     <= 7'd0;
      tx_sr_reg     <= 8'hFF;
      miso_reg      <= 1'b1;
    end else begin
      sclk_prev_reg <= sclk_s;
      if (cs_s) begin
        bit_cnt_reg <= 3'd0;
        tx_sr_reg   <= 8'hFF;
        miso_reg    <= 1'b1;
      end else if (rise) begin
        rx_sr_reg   <= rx_byte[6:0];
        bit_cnt_reg <= bit_cnt_reg + 3'd1;
        if (bit_cnt_reg == 3'd7) tx_sr_reg <= tx_load;
      end else if (fall) begin
        miso_reg  <= tx_sr_reg[7];
        tx_sr_reg <= {tx_sr_reg[6:0], 1'b1};
      end
    end
  end

  state_t            state_reg, state_next, after_reg, after_next;
  logic [2:0]        cmd_cnt_reg, cmd_cnt_next;
  logic [8:0]        cnt_reg, cnt_next;
  logic [5:0]        cmd_idx_reg, cmd_idx_next;
  logic [ARG_W-1:0]  arg_reg, arg_next;
  logic [39:0]       resp_sr_reg, resp_sr_next;
  logic [2:0]        resp_left_reg, resp_left_next;
  logic              app_flag_reg, app_flag_next;
  logic [7:0]        retry_reg, retry_next;
  logic              ready_reg, ready_next;
  logic [5:0]        last_cmd_reg, last_cmd_next;
  logic              mem_rd_reg, mem_rd_next;
  logic              mem_wr_reg, mem_wr_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [7:0]        wdata_reg, wdata_next;
  logic              rd_cap_reg;
  logic [7:0]        rd_buf_reg;
  logic [7:0]        r1;
  logic [31:0]       tail;
  logic              idle_bit;

  assign idle_bit = ~ready_reg;

  // Byte-level protocol: next state, next tx byte and memory strobes
  always_comb begin
    state_next     = state_reg;
    after_next     = after_reg;
    cmd_cnt_next   = cmd_cnt_reg;
    cnt_next       = cnt_reg;
    cmd_idx_next   = cmd_idx_reg;
    arg_next       = arg_reg;
    resp_sr_next   = resp_sr_reg;
    resp_left_next = resp_left_reg;
    app_flag_next  = app_flag_reg;
    retry_next     = retry_reg;
    ready_next     = ready_reg;
    last_cmd_next  = last_cmd_reg;
    mem_rd_next    = 1'b0;
    mem_wr_next    = 1'b0;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    tx_load        = 8'hFF;
    r1             = {7'b0, idle_bit};
    tail           = 32'h0;
    if (byte_done) begin
      case (state_reg)
        S_CMD: begin
          if (cmd_cnt_reg == 3'd0) begin
            // Only a start byte of the form 01xxxxxx opens a frame.
            if (rx_byte[7:6] == 2'b01) begin
              cmd_idx_next = rx_byte[5:0];
              cmd_cnt_next = 3'd1;
            end
          end else if (cmd_cnt_reg < 3'd5) begin
            arg_next     = ARG_W'({arg_reg, rx_byte});
            cmd_cnt_next = cmd_cnt_reg + 3'd1;
          end else begin
            // CRC byte: decode; the byte loaded now is the NCR filler.
            cmd_cnt_next   = 3'd0;
            last_cmd_next  = cmd_idx_reg;
            app_flag_next  = 1'b0;
            state_next     = S_RESP;
            after_next     = S_CMD;
            resp_left_next = 3'd1;
            case (cmd_idx_reg)
              6'd0: begin
                r1         = 8'h01;
                ready_next = 1'b0;
                retry_next = 8'd0;
              end
              6'd8: begin
                tail           = {24'h000001, arg_reg[7:0]};
                resp_left_next = 3'd5;
              end
              6'd55: app_flag_next = 1'b1;
              6'd41: begin
                if (!app_flag_reg) begin
                  r1 = {5'b0, 1'b1, 1'b0, idle_bit};
                end else if (retry_reg < RETRY_MAX) begin
                  r1         = 8'h01;
                  retry_next = retry_reg + 8'd1;
                end else begin
                  r1         = 8'h00;
                  ready_next = 1'b1;
                end
              end
              6'd58: begin
                tail           = 32'hC0FF8000;
                resp_left_next = 3'd5;
              end
              6'd16: ;
              6'd17, 6'd24: begin
                if (!ready_reg) begin
                  r1 = 8'h05;
                end else begin
                  r1         = 8'h00;
                  after_next = (cmd_idx_reg == 6'd17) ? S_RD_NAC : S_WR_WAIT;
                end
              end
              default: r1 = {5'b0, 1'b1, 1'b0, idle_bit};
            endcase
            resp_sr_next = {r1, tail};
          end
        end
        S_RESP: begin
          tx_load        = resp_sr_reg[39:32];
          resp_sr_next   = {resp_sr_reg[31:0], 8'hFF};
          resp_left_next = resp_left_reg - 3'd1;
          if (resp_left_reg == 3'd1) begin
            state_next = after_reg;
            cnt_next   = 9'd0;
          end
        end
        S_RD_NAC: begin
          if (cnt_reg == NAC_MAX) begin
            // Token goes out now; fetch data byte 0 while it shifts.
            tx_load     = 8'hFE;
            state_next  = S_RD_DATA;
            cnt_next    = 9'd0;
            mem_rd_next = 1'b1;
            addr_next   = {arg_reg, 9'd0};
          end else begin
            cnt_next = cnt_reg + 9'd1;
          end
        end
        S_RD_DATA: begin
          tx_load = rd_buf_reg;
          if (cnt_reg == 9'd511) begin
            state_next = S_RD_CRC;
            cnt_next   = 9'd0;
          end else begin
            cnt_next    = cnt_reg + 9'd1;
            mem_rd_next = 1'b1;
            addr_next   = {arg_reg, cnt_reg + 9'd1};
          end
        end
        S_RD_CRC: begin
          if (cnt_reg == 9'd1) state_next = S_CMD;
          else cnt_next = cnt_reg + 9'd1;
        end
        S_WR_WAIT: begin
          if (rx_byte == 8'hFE) begin
            state_next = S_WR_DATA;
            cnt_next   = 9'd0;
          end
        end
        S_WR_DATA: begin
          mem_wr_next = 1'b1;
          wdata_next  = rx_byte;
          addr_next   = {arg_reg, cnt_reg};
          if (cnt_reg == 9'd511) begin
            state_next = S_WR_CRC;
            cnt_next   = 9'd0;
          end else begin
            cnt_next = cnt_reg + 9'd1;
          end
        end
        S_WR_CRC: begin
          if (cnt_reg == 9'd1) begin
            tx_load    = 8'h05;
            state_next = S_WR_RESP;
          end else begin
            cnt_next = cnt_reg + 9'd1;
          end
        end
        S_WR_RESP: begin
          if (BUSY_MAX == 9'd0) begin
            state_next = S_CMD;
          end else begin
            tx_load    = 8'h00;
            state_next = S_WR_BUSY;
            cnt_next   = 9'd1;
          end
        end
        S_WR_BUSY: begin
          if (cnt_reg == BUSY_MAX) begin
            state_next = S_CMD;
          end else begin
            tx_load  = 8'h00;
            cnt_next = cnt_reg + 9'd1;
          end
        end
        default: state_next = S_CMD;
      endcase
    end
    // Deselect aborts whatever transfer is in flight.
    if (cs_s) begin
      state_next   = S_CMD;
      cmd_cnt_next = 3'd0;
      cnt_next     = 9'd0;
      mem_rd_next  = 1'b0;
      mem_wr_next  = 1'b0;
    end
  end

  // Protocol state and memory-interface registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_CMD;
      after_reg     <= S_CMD;
      cmd_cnt_reg   <= 3'd0;
      cnt_reg       <= 9'd0;
      cmd_idx_reg   <= 6'd0;
      arg_reg       <= '0;
      resp_sr_reg   <= '1;
      resp_left_reg <= 3'd0;
      app_flag_reg  <= 1'b0;
      retry_reg     <= 8'd0;
      ready_reg     <= 1'b0;
      last_cmd_reg  <= 6'd0;
      mem_rd_reg    <= 1'b0;
      mem_wr_reg    <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= 8'd0;
    end else begin
      state_reg     <= state_next;
      after_reg     <= after_next;
      cmd_cnt_reg   <= cmd_cnt_next;
      cnt_reg       <= cnt_next;
      cmd_idx_reg   <= cmd_idx_next;
      arg_reg       <= arg_next;
      resp_sr_reg   <= resp_sr_next;
      resp_left_reg <= resp_left_next;
      app_flag_reg  <= app_flag_next;
      retry_reg     <= retry_next;
      ready_reg     <= ready_next;
      last_cmd_reg  <= last_cmd_next;
      mem_rd_reg    <= mem_rd_next;
      mem_wr_reg    <= mem_wr_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
    end
  end

  // Capture read data the cycle after the memory saw the strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cap_reg <= 1'b0;
      rd_buf_reg <= 8'hFF;
    end else begin
      rd_cap_reg <= mem_rd_reg;
      if (rd_cap_reg) rd_buf_reg <= mem_rdata;
    end
  end

  assign spi_miso   = miso_reg;
  assign mem_addr   = addr_reg;
  assign mem_rd     = mem_rd_reg;
  assign mem_wr     = mem_wr_reg;
  assign mem_wdata  = wdata_reg;
  assign card_ready = ready_reg;
  assign card_state = state_reg;
  assign last_cmd   = last_cmd_reg;

endmodule
